// File: rtl/clint_smp_if.sv
// Single-request word bus from the MMIO decode into the CLINT.
// The response (r_ack, r_rdata) follows the request by one cycle.
interface clint_smp_if;
  logic        w_req;
  logic        w_we;
  logic [15:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] r_rdata;
  logic        r_ack;

  modport master (
    output w_req, w_we, w_addr, w_wdata,
    input  r_rdata, r_ack
  );

  modport slave (
    input  w_req, w_we, w_addr, w_wdata,
    output r_rdata, r_ack
  );
endinterface

// File: rtl/clint_smp.sv
// Core-local interruptor: shared 64-bit mtime with prescaler, per-hart mtimecmp and msip,
// registered timer interrupts and a 1-cycle-latency register bus.
module clint_smp #(
  parameter int unsigned N_HARTS  = 1,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic               CLK,
  input  logic               RST,
  clint_smp_if.slave         bus,
  output logic [N_HARTS-1:0] w_mtip,
  output logic [N_HARTS-1:0] w_msip,
  output logic [63:0]        w_mtime
);

  localparam int unsigned   PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);

  logic [PW-1:0]            presc_q, presc_d;
  logic [63:0]              mtime_q, mtime_d;
  logic [N_HARTS-1:0][63:0] cmp_q, cmp_d;
  logic [N_HARTS-1:0]       msip_q, msip_d;
  logic [N_HARTS-1:0]       mtip_q, mtip_d;
  logic                     ack_q;
  logic [31:0]              rdata_q;
  logic [31:0]              rd_val;

  logic        tick, wr, rd;
  logic        mtime_lo_sel, mtime_hi_sel, msip_sel, cmp_sel;
  logic [13:0] msip_idx;
  logic [12:0] cmp_idx;
  logic        addr_unused;

  assign tick         = (presc_q == PrescMax);
  assign wr           = bus.w_req & bus.w_we;
  assign rd           = bus.w_req & ~bus.w_we;
  assign mtime_lo_sel = (bus.w_addr[15:2] == 14'h2FFE);
  assign mtime_hi_sel = (bus.w_addr[15:2] == 14'h2FFF);
  assign msip_sel     = (bus.w_addr[15:14] == 2'b00);
  // mtimecmp window spans 0x4000..0xBFF7; mtime sits at its top end
  assign cmp_sel      = ((bus.w_addr[15:14] == 2'b01) || (bus.w_addr[15:14] == 2'b10)) &&
                        !mtime_lo_sel && !mtime_hi_sel;
  assign msip_idx     = bus.w_addr[15:2];
  assign cmp_idx      = bus.w_addr[15:3] - 13'h0800;
  assign addr_unused  = ^bus.w_addr[1:0];

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    msip_d  = msip_q;
    cmp_d   = cmp_q;
    mtip_d  = '0;
    rd_val  = '0;

    // A write to either mtime half suppresses that cycle's increment
    if (wr && mtime_lo_sel) mtime_d = {mtime_q[63:32], bus.w_wdata};
    if (wr && mtime_hi_sel) mtime_d = {bus.w_wdata, mtime_q[31:0]};
    if (mtime_lo_sel) rd_val = mtime_q[31:0];
    if (mtime_hi_sel) rd_val = mtime_q[63:32];

    for (int h = 0; h < N_HARTS; h++) begin
      mtip_d[h] = (mtime_q >= cmp_q[h]);
      if (msip_sel && (msip_idx == 14'(h))) begin
        rd_val = {31'b0, msip_q[h]};
        if (wr) msip_d[h] = bus.w_wdata[0];
      end
      if (cmp_sel && (cmp_idx == 13'(h))) begin
        if (bus.w_addr[2]) begin
          rd_val = cmp_q[h][63:32];
          if (wr) cmp_d[h][63:32] = bus.w_wdata;
        end else begin
          rd_val = cmp_q[h][31:0];
          if (wr) cmp_d[h][31:0] = bus.w_wdata;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q <= '0;
      mtime_q <= '0;
      cmp_q   <= '1;
      msip_q  <= '0;
      mtip_q  <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      msip_q  <= msip_d;
      mtip_q  <= mtip_d;
      ack_q   <= bus.w_req;
      if (rd) rdata_q <= rd_val;
    end
  end

  assign bus.r_ack   = ack_q;
  assign bus.r_rdata = rdata_q;
  assign w_mtip      = mtip_q;
  assign w_msip      = msip_q;
  assign w_mtime     = mtime_q;

endmodule

// File: tb/tb_clint_smp.sv
// Bench for clint_smp: a TICK_DIV=1 instance checked through a read-data scoreboard,
// plus a TICK_DIV=4 instance for prescaler and reset-value checks.
module tb_clint_smp;

  localparam int unsigned NH = 2;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  clint_smp_if bus1 ();
  clint_smp_if bus4 ();

  logic [NH-1:0] mtip1, msip1, mtip4, msip4;
  logic [63:0]   mtime1, mtime4;

  clint_smp #(.N_HARTS(NH), .TICK_DIV(1)) u_dut1 (
    .CLK     (CLK),
    .RST     (RST),
    .bus     (bus1),
    .w_mtip  (mtip1),
    .w_msip  (msip1),
    .w_mtime (mtime1)
  );

  clint_smp #(.N_HARTS(NH), .TICK_DIV(4)) u_dut4 (
    .CLK     (CLK),
    .RST     (RST),
    .bus     (bus4),
    .w_mtip  (mtip4),
    .w_msip  (msip4),
    .w_mtime (mtime4)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Call at posedge+1; returns at posedge+1 of the edge that sampled the request.
  // For writes the expected response keeps the last read data.
  task automatic access1(input logic we, input logic [15:0] addr, input logic [31:0] data);
    bus1.w_req   = 1'b1;
    bus1.w_we    = we;
    bus1.w_addr  = addr;
    bus1.w_wdata = we ? data : 32'h0;
    if (!RST) begin
      if (!we) last_rd = data;
      exp_q.push_back(last_rd);
    end else begin
      last_rd = '0;
    end
    @(posedge CLK);
    #1;
    bus1.w_req = 1'b0;
    bus1.w_we  = 1'b0;
  endtask

  task automatic read4(input logic [15:0] addr, input logic [31:0] exp);
    bus4.w_req  = 1'b1;
    bus4.w_we   = 1'b0;
    bus4.w_addr = addr;
    @(posedge CLK);
    #1;
    bus4.w_req = 1'b0;
    check_eq("ack4", bus4.r_ack, 1);
    check_eq("rdata4", bus4.r_rdata, exp);
  endtask

  // Response monitor for the TICK_DIV=1 instance
  initial begin
    logic req_s, rst_s;
    forever begin
      @(posedge CLK);
      req_s = bus1.w_req;
      rst_s = RST;
      #1;
      check_eq("ack", bus1.r_ack, req_s && !rst_s);
      if (bus1.r_ack === 1'b1) begin
        if (exp_q.size() > 0) check_eq("rdata", bus1.r_rdata, exp_q.pop_front());
        else check_eq("ack_without_req", bus1.r_ack, 0);
      end
    end
  end

  initial begin
    RST          = 1'b1;
    bus1.w_req   = 1'b0;
    bus1.w_we    = 1'b0;
    bus1.w_addr  = '0;
    bus1.w_wdata = '0;
    bus4.w_req   = 1'b0;
    bus4.w_we    = 1'b0;
    bus4.w_addr  = '0;
    bus4.w_wdata = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    check_eq("rst_mtime1", mtime1, 0);
    check_eq("rst_mtime4", mtime4, 0);
    check_eq("rst_mtip1", mtip1, 0);
    check_eq("rst_msip1", msip1, 0);
    check_eq("rst_rdata1", bus1.r_rdata, 0);

    // Prescaler: 40 cycles at TICK_DIV=4 gives 10 ticks
    repeat (40) @(posedge CLK);
    #1;
    check_eq("mtime4_40", mtime4, 64'd10);
    check_eq("mtime1_40", mtime1, 64'd40);
    check_eq("mtip4", mtip4, 0);
    check_eq("msip4", msip4, 0);
    read4(16'h4000, 32'hFFFF_FFFF);
    read4(16'h4004, 32'hFFFF_FFFF);
    access1(1'b0, 16'h4000, 32'hFFFF_FFFF);

    // Timer interrupt timing
    access1(1'b1, 16'h4000, 32'd100);
    access1(1'b1, 16'h4004, 32'd0);
    access1(1'b1, 16'hBFF8, 32'd95);
    check_eq("mtime_wr", mtime1, 64'd95);
    check_eq("mtip_pre", mtip1[0], 0);
    for (int i = 1; i <= 6; i++) begin
      @(posedge CLK);
      #1;
      check_eq("mtime_run", mtime1, 64'd95 + 64'(i));
      check_eq("mtip_rise", mtip1[0], (i >= 6) ? 1'b1 : 1'b0);
    end
    access1(1'b1, 16'h4000, 32'd1000);
    check_eq("mtip_lag", mtip1[0], 1);
    @(posedge CLK);
    #1;
    check_eq("mtip_fall", mtip1[0], 0);

    // Software interrupts
    access1(1'b1, 16'h0004, 32'hFFFF_FFFF);
    check_eq("msip_set", msip1, 2'b10);
    access1(1'b0, 16'h0004, 32'd1);
    access1(1'b1, 16'h0004, 32'd0);
    check_eq("msip_clr", msip1, 2'b00);

    // mtime carry and wrap
    access1(1'b1, 16'hBFFC, 32'd0);
    access1(1'b1, 16'hBFF8, 32'hFFFF_FFFF);
    check_eq("mtime_lo_ones", mtime1, 64'h0000_0000_FFFF_FFFF);
    @(posedge CLK);
    #1;
    check_eq("mtime_carry", mtime1, 64'h0000_0001_0000_0000);
    access1(1'b1, 16'hBFFC, 32'hFFFF_FFFF);
    access1(1'b1, 16'hBFF8, 32'hFFFF_FFFF);
    check_eq("mtime_ones", mtime1, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge CLK);
    #1;
    check_eq("mtime_wrap", mtime1, 64'd0);
    access1(1'b0, 16'hBFF8, 32'd0);
    access1(1'b0, 16'hBFFC, 32'd0);

    // Unmapped and out-of-range harts, back-to-back
    access1(1'b0, 16'h1234, 32'd0);
    access1(1'b0, 16'h0014, 32'd0);
    access1(1'b1, 16'h1234, 32'hFFFF_FFFF);
    access1(1'b0, 16'h0000, 32'd0);
    access1(1'b0, 16'h4000, 32'd1000);
    access1(1'b0, 16'h4004, 32'd0);
    access1(1'b0, 16'h4008, 32'hFFFF_FFFF);
    access1(1'b0, 16'h4010, 32'd0);
    check_eq("msip_unmapped", msip1, 2'b00);

    // Reset on the edge that samples a read drops its ack
    RST = 1'b1;
    access1(1'b0, 16'h4000, 32'd1000);
    RST = 1'b0;
    check_eq("rst2_ack", bus1.r_ack, 0);
    check_eq("rst2_rdata", bus1.r_rdata, 0);
    check_eq("rst2_mtime1", mtime1, 0);
    check_eq("rst2_mtime4", mtime4, 0);
    check_eq("rst2_mtip1", mtip1, 0);
    check_eq("rst2_msip1", msip1, 0);
    access1(1'b0, 16'h4000, 32'hFFFF_FFFF);

    repeat (2) @(posedge CLK);
    #1;
    check_eq("sb_drained", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clint_smp.md
Name: clint_smp

Overview:
Core-local interruptor for the multi-hart RV cluster. Holds the shared 64-bit mtime counter, one mtimecmp per hart and one msip bit per hart. Drives the cluster's per-hart timer and software interrupt lines and its mtime input. Register accesses arrive from the memory-controller MMIO decode through a single-request, 1-cycle-latency word bus.

Parameters:
N_HARTS, 1, number of harts; sets the width of w_mtip/w_msip and the number of mtimecmp/msip registers (1..16)
TICK_DIV, 1, CLK cycles per mtime increment (>=1); 1 = increment every cycle

Ports:
CLK  in  1  clock; all state updates on its rising edge
RST  in  1  synchronous, active-high reset
w_req  in  1  access request, one per cycle, single-cycle pulse
w_we  in  1  1 = write, 0 = read; sampled with w_req
w_addr  in  16  byte offset within the CLINT window; bits [1:0] ignored
w_wdata  in  32  write data; full 32-bit word only
r_rdata  out  32  read data; valid when r_ack=1 for a read; held until the next ack
r_ack  out  1  pulses 1 cycle after every w_req (read or write)
w_mtip  out  N_HARTS  registered per-hart timer interrupt: mtime >= mtimecmp[h]
w_msip  out  N_HARTS  per-hart software interrupt: msip[h] bit 0
w_mtime  out  64  current mtime register value

Behaviour:
- Register map (word offsets):
  - msip[h] at 0x0000+4h
  - mtimecmp[h] low at 0x4000+8h, high at 0x4004+8h
  - mtime low at 0xBFF8, mtime high at 0xBFFC
- Reset (RST=1 on a clock edge):
  - mtime=0, prescaler=0
  - every mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, every msip=0
  - w_mtip=0, r_ack=0, r_rdata=0
  - Any request in the reset cycle is dropped: no ack follows.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - mtime increments by 1 on the cycle the prescaler equals TICK_DIV-1.
  - TICK_DIV=1: increment every cycle.
  - mtime wraps 2^64-1 -> 0 with no flag.
- mtime write:
  - Low or high word write replaces that half; the other half holds.
  - No increment in that cycle; the prescaler still advances.
  - The written value is visible on w_mtime the next cycle.
- mtimecmp write: replaces the addressed half only. No atomicity protection; a spurious mtip between the two half-writes is permitted.
- msip write: only wdata[0] is stored. Reads return {31'b0, msip[h]}.
- w_mtip[h]:
  - Registered; 1-cycle lag from the mtime/mtimecmp values.
  - Unsigned 64-bit compare, recomputed every cycle.
  - Level, not sticky: clears once mtimecmp is raised above mtime.
- w_msip is driven directly from the msip registers (no extra latency beyond the write edge).
- Reads:
  - r_rdata in cycle t+1 returns the register value as of cycle t, before any update at that edge.
  - mtime reads therefore return the pre-increment value.
- Writes: r_ack=1 in cycle t+1; r_rdata unchanged.
- Unmapped offsets, and hart index >= N_HARTS: reads return 0, writes are ignored, ack is still given.
- Back-to-back requests on consecutive cycles are all acknowledged, one ack per request, in order.
- A reset asserted between a request and its ack suppresses that ack.

Test Plan:
- Reset, TICK_DIV=4, run 40 cycles -> w_mtime=10; w_mtip=0; w_msip=0; mtimecmp[0] reads 32'hFFFFFFFF at both halves.
- TICK_DIV=1; write mtimecmp[0] lo=100, hi=0; write mtime lo=95 -> w_mtip[0] rises exactly 6 cycles after mtime=95 is visible (mtime=100 plus the 1-cycle register lag); writing mtimecmp lo=1000 -> w_mtip[0] falls the cycle after the write.
- N_HARTS=2: write msip[1]=32'hFFFFFFFF -> w_msip=2'b10; read 0x0004 -> r_ack next cycle, r_rdata=1; write msip[1]=0 -> w_msip=0.
- Write mtime hi=0, lo=32'hFFFFFFFF with TICK_DIV=1 -> after one increment w_mtime=64'h1_0000_0000; write both halves to all-ones -> wraps to 0 on the next tick.
- Read 0x1234 and msip[5] with N_HARTS=2 -> r_ack=1, r_rdata=0; write to 0x1234 -> no register changes.
- Issue a read, assert RST on the following edge -> no r_ack; all outputs at reset values next cycle.
